// File: rtl/div_request_scheduler_pkg.sv
// Shared types and constants for the divider request scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Wide enough to hold 0..timeout so the final increment cannot wrap.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/div_request_scheduler_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module div_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_request_scheduler.sv
// Shares one iterative divider between NREQ requesters: round-robin grant,
// start pulse, bounded wait for completion, tagged response.
module div_request_scheduler
    import div_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_dividend,
    input  logic [NREQ*W-1:0]        req_divisor,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_quotient,
    output logic [W-1:0]             rsp_remainder,
    output logic [1:0]               rsp_err,
    output logic                     div_start,
    output logic [W-1:0]             div_dividend,
    output logic [W-1:0]             div_divisor,
    input  logic                     div_done,
    input  logic [W-1:0]             div_quotient,
    input  logic [W-1:0]             div_remainder,
    output logic                     busy
);

    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [W-1:0]    sel_dividend;
    logic [W-1:0]    sel_divisor;
    logic            timed_out;

    div_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign sel_dividend = req_dividend[arb_idx*W +: W];
    assign sel_divisor  = req_divisor[arb_idx*W +: W];
    assign timed_out    = (cnt == CNT_W'(TIMEOUT - 1));

    // Grants only exist while IDLE; the RESP accept cycle never grants.
    assign req_ready    = (state == ST_IDLE) ? arb_grant : '0;
    assign div_start    = (state == ST_ISSUE);
    assign rsp_valid    = (state == ST_RESP);
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = (sel_divisor == '0) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (div_done || timed_out) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && arb_any)
                ptr <= IW'((int'(arb_idx) + 1) % NREQ);
            if (state == ST_ISSUE)
                cnt <= '0;
            else if (state == ST_WAIT)
                cnt <= cnt + 1'b1;
        end
    end

    // Operand capture at grant, result capture on completion or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id        <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_err       <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        rsp_id       <= arb_idx;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            rsp_quotient  <= '1;
                            rsp_remainder <= sel_dividend;
                            rsp_err       <= ERR_DIV0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (div_done) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_err       <= ERR_OK;
                    end else if (timed_out) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_err       <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_request_scheduler.sv
// Scoreboard bench for div_request_scheduler with a behavioural divider model.
module tb_div_request_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int TO   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_quotient;
    logic [W-1:0]      rsp_remainder;
    logic [1:0]        rsp_err;
    logic              div_start;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_done;
    logic [W-1:0]      div_quotient;
    logic [W-1:0]      div_remainder;
    logic              busy;

    div_request_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int q;
        int r;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   starts = 0;
    int   last_grant_cyc = 0;
    int   done_cyc = 0;
    bit   expect_timeout = 0;
    logic [NREQ-1:0] prev_ready = '0;

    int         model_dly = 5;
    bit         model_hang = 0;
    bit         stray = 0;
    int         pend = 0;
    logic [W-1:0] ma, mb;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (div_start) starts++;

    // Divider model: answers model_dly cycles after the start pulse.
    initial begin
        div_done = 0;
        div_quotient = '0;
        div_remainder = '0;
        forever begin
            @(posedge clk); #1;
            div_done = 0;
            if (stray) begin
                div_done = 1;
                div_quotient = 4'd5;
                div_remainder = 4'd5;
                stray = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    div_done = 1;
                    div_quotient = ma / mb;
                    div_remainder = ma % mb;
                    done_cyc = cyc;
                end
            end
            if (div_start && !model_hang) begin
                pend = model_dly;
                ma = div_dividend;
                mb = div_divisor;
            end
        end
    end

    // Grant logger: pushes the expected response for every accepted request.
    always @(negedge clk) begin
        if (!rst && req_ready != '0) begin
            int g;
            logic [W-1:0] a, b;
            exp_t e;
            g = 0;
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
            chk("ready_onehot", int'($onehot(req_ready)), 1);
            chk("ready_pulse", int'(prev_ready), 0);
            a = req_dividend[g*W +: W];
            b = req_divisor[g*W +: W];
            e.id = g;
            if (expect_timeout) begin
                e.q = 0; e.r = 0; e.err = 2;
            end else if (b == 0) begin
                e.q = 15; e.r = int'(a); e.err = 1;
            end else begin
                e.q = int'(a) / int'(b); e.r = int'(a) % int'(b); e.err = 0;
            end
            exp_q.push_back(e);
            grant_q.push_back(g);
            last_grant_cyc = cyc;
        end
        prev_ready = req_ready;
    end

    // Response monitor: compares every accepted response to the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_quotient", int'(rsp_quotient), e.q);
                chk("rsp_remainder", int'(rsp_remainder), e.r);
                chk("rsp_err", int'(rsp_err), e.err);
            end
        end
    end

    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req_valid[i] = 1'b1;
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W] = b;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        if (!got) chk("grant_bound", 0, 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        bit got;
        got = 0;
        c = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                c = cyc;
            end
        end
        if (!got) chk("rsp_bound", 0, 1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        if (!got) chk("idle_bound", 0, 1);
    endtask

    initial begin
        int c, t, s0, base;
        bit ok;
        rst = 1;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_div_start", int'(div_start), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_quotient", int'(rsp_quotient), 0);
        chk("rst_remainder", int'(rsp_remainder), 0);
        chk("rst_err", int'(rsp_err), 0);

        // single request 13/3 from requester 2
        model_dly = 5;
        send(2, 4'd13, 4'd3);
        wait_rsp(c);
        chk("single_done_to_rsp", c - done_cyc, 1);
        wait_idle();

        // divide-by-zero from requester 0
        s0 = starts;
        send(0, 4'd9, 4'd0);
        t = last_grant_cyc;
        wait_rsp(c);
        chk("div0_latency", c - t, 1);
        wait_idle();
        chk("div0_no_start", starts, s0);

        // fairness after a reset returns the pointer to 0
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        model_dly = 2;
        base = grant_q.size();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*W +: W] = 4'(8 + i);
            req_divisor[i*W +: W] = 4'(i + 1);
        end
        req_valid = '1;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (grant_q.size() >= base + 6) ok = 1;
        end
        @(posedge clk); #1 req_valid = '0;
        wait_idle();
        if (!ok) chk("fair_bound", 0, 1);
        else for (int k = 0; k < 6; k++) chk("fair_order", grant_q[base + k], k % 4);

        // timeout, then stray done, then a normal request
        model_hang = 1;
        expect_timeout = 1;
        send(1, 4'd7, 4'd2);
        t = last_grant_cyc;
        wait_rsp(c);
        chk("timeout_latency", c - t, TO + 2);
        wait_idle();
        expect_timeout = 0;
        stray = 1;
        repeat (4) begin
            @(negedge clk);
            chk("stray_ignored", int'(rsp_valid | busy), 0);
        end
        model_hang = 0;
        model_dly = 3;
        send(3, 4'd14, 4'd5);
        wait_rsp(c);
        wait_idle();

        // backpressure with a competing requester waiting
        rsp_ready = 0;
        send(2, 4'd15, 4'd4);
        wait_rsp(c);
        @(posedge clk); #1;
        req_dividend[0 +: W] = 4'd6;
        req_divisor[0 +: W] = 4'd3;
        req_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_quotient", int'(rsp_quotient), 3);
            chk("bp_remainder", int'(rsp_remainder), 3);
            chk("bp_err", int'(rsp_err), 0);
            chk("bp_id", int'(rsp_id), 2);
            chk("bp_no_grant", int'(req_ready), 0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        chk("bp_accept_no_grant", int'(req_ready), 0);
        @(negedge clk);
        chk("bp_regrant", int'(req_ready), 1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_rsp(c);
        wait_idle();

        // reset while waiting on the divider
        model_dly = 6;
        send(1, 4'd9, 4'd2);
        repeat (3) @(negedge clk);
        chk("rw_in_wait", int'(busy), 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        exp_q.delete();
        @(negedge clk);
        chk("rw_busy", int'(busy), 0);
        chk("rw_rsp_valid", int'(rsp_valid), 0);
        repeat (10) begin
            @(negedge clk);
            chk("rw_no_rsp", int'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        req_dividend[0 +: W] = 4'd12;
        req_divisor[0 +: W] = 4'd4;
        req_dividend[3*W +: W] = 4'd5;
        req_divisor[3*W +: W] = 4'd1;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("rw_ptr_zero", int'(req_ready), 1);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(c);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
